// File: rtl/led_interface_router.sv
// Maps per-channel user codes to LED outputs; each output is owned by one channel via round-robin with hold timeout.
// Grant latency 1 cycle from sampled req; every release leaves one blank cycle before the next grant.
module led_interface_router #(
    parameter int NCH         = 4,
    parameter int CODEW       = 3,
    parameter int NOUT        = 2,
    parameter int MODE        = 0,
    parameter int HOLD_CYCLES = 16,
    localparam int DW         = $clog2(NOUT),
    localparam int CW         = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        req,
    input  logic [NCH*CODEW-1:0]  code,
    output logic [NCH-1:0]        gnt,
    output logic [NCH*DW-1:0]     ledsel,
    output logic [NOUT-1:0]       out_busy,
    output logic [NOUT*CW-1:0]    out_owner
);

    localparam int HMAX = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
    localparam int HW   = (HMAX > 0) ? $clog2(HMAX + 1) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t          state_q [NOUT];
    state_t          state_d [NOUT];
    logic [CW-1:0]   owner_q [NOUT];
    logic [CW-1:0]   owner_d [NOUT];
    logic [CW-1:0]   ptr_q   [NOUT];
    logic [CW-1:0]   ptr_d   [NOUT];
    logic [HW-1:0]   cnt_q   [NOUT];
    logic [HW-1:0]   cnt_d   [NOUT];
    logic [DW-1:0]   ledsel_q [NCH];
    logic [DW-1:0]   ledsel_d [NCH];
    logic [NCH-1:0]  gnt_q;
    logic [NCH-1:0]  gnt_d;
    logic [DW-1:0]   dest [NCH];

    always_comb begin
        logic [CODEW+2:0] cx;
        cx = '0;
        for (int i = 0; i < NCH; i++) begin
            cx = {3'b000, code[i*CODEW +: CODEW]};
            if (MODE == 0) begin
                dest[i] = (cx[0] && (cx[2] != cx[1])) ? DW'(0) : DW'(1);
            end else begin
                dest[i] = DW'(32'(code[i*CODEW +: CODEW]) % 32'(NOUT));
            end
        end
    end

    always_comb begin
        logic [NCH-1:0] cand;
        logic           found;
        int             sel;
        int             idx;
        int             k;
        cand  = '0;
        found = 1'b0;
        sel   = 0;
        idx   = 0;
        k     = 0;
        gnt_d = '0;
        for (int i = 0; i < NCH; i++) ledsel_d[i] = ledsel_q[i];
        for (int j = 0; j < NOUT; j++) begin
            state_d[j] = state_q[j];
            owner_d[j] = owner_q[j];
            ptr_d[j]   = ptr_q[j];
            cnt_d[j]   = cnt_q[j];
        end

        for (int j = 0; j < NOUT; j++) begin
            // A channel still holding an output waits for its release before competing elsewhere.
            for (int i = 0; i < NCH; i++) begin
                cand[i] = req[i] && (dest[i] == DW'(j)) && !gnt_q[i];
            end
            if (state_q[j] == IDLE) begin
                found = 1'b0;
                sel   = 0;
                for (int off = 1; off <= NCH; off++) begin
                    idx = (int'(ptr_q[j]) + off) % NCH;
                    if (!found && cand[idx]) begin
                        found = 1'b1;
                        sel   = idx;
                    end
                end
                if (found) begin
                    state_d[j]    = OWNED;
                    owner_d[j]    = CW'(sel);
                    ptr_d[j]      = CW'(sel);
                    cnt_d[j]      = '0;
                    ledsel_d[sel] = DW'(j);
                end
            end else begin
                k = int'(owner_q[j]);
                if (!req[k] || (dest[k] != DW'(j)) ||
                    ((HOLD_CYCLES > 0) && (cnt_q[j] == HW'(HMAX)) && (|cand))) begin
                    state_d[j] = IDLE;
                    owner_d[j] = '0;
                end else if (cnt_q[j] != HW'(HMAX)) begin
                    cnt_d[j] = cnt_q[j] + HW'(1);
                end
            end
        end

        for (int i = 0; i < NCH; i++) begin
            for (int j = 0; j < NOUT; j++) begin
                if ((state_d[j] == OWNED) && (owner_d[j] == CW'(i))) gnt_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q <= '0;
            for (int i = 0; i < NCH; i++) ledsel_q[i] <= '0;
            for (int j = 0; j < NOUT; j++) begin
                state_q[j] <= IDLE;
                owner_q[j] <= '0;
                ptr_q[j]   <= CW'(NCH - 1);
                cnt_q[j]   <= '0;
            end
        end else begin
            gnt_q <= gnt_d;
            for (int i = 0; i < NCH; i++) ledsel_q[i] <= ledsel_d[i];
            for (int j = 0; j < NOUT; j++) begin
                state_q[j] <= state_d[j];
                owner_q[j] <= owner_d[j];
                ptr_q[j]   <= ptr_d[j];
                cnt_q[j]   <= cnt_d[j];
            end
        end
    end

    assign gnt = gnt_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ledsel
        assign ledsel[i*DW +: DW] = ledsel_q[i];
    end

    for (genvar j = 0; j < NOUT; j++) begin : g_out
        assign out_busy[j]           = (state_q[j] == OWNED);
        assign out_owner[j*CW +: CW] = owner_q[j];
    end

endmodule

// File: tb/tb_led_interface_router.sv
// Directed bench for led_interface_router: MODE=1 instance for arbitration, MODE=0 instance for the legacy map.
module tb_led_interface_router;

    localparam int NCH = 4, CODEW = 3, NOUT = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NCH-1:0]   req = '0;
    logic [NCH*CODEW-1:0] code = '0;
    logic [NCH-1:0]   gnt, gnt_l;
    logic [NCH-1:0]   ledsel, ledsel_l;
    logic [NOUT-1:0]  out_busy, busy_l;
    logic [NOUT*2-1:0] out_owner, owner_l;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] v;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    led_interface_router #(.NCH(NCH), .CODEW(CODEW), .NOUT(NOUT), .MODE(1), .HOLD_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .req(req), .code(code),
        .gnt(gnt), .ledsel(ledsel), .out_busy(out_busy), .out_owner(out_owner)
    );

    led_interface_router #(.NCH(NCH), .CODEW(CODEW), .NOUT(NOUT), .MODE(0), .HOLD_CYCLES(4)) dut_leg (
        .clk(clk), .rst(rst), .req(req), .code(code),
        .gnt(gnt_l), .ledsel(ledsel_l), .out_busy(busy_l), .out_owner(owner_l)
    );

    function automatic logic [31:0] obs(int kind);
        case (kind)
            0: return 32'(gnt);
            1: return 32'(out_busy);
            2: return 32'(out_owner);
            3: return 32'(ledsel);
            4: return 32'(gnt_l);
            5: return 32'(ledsel_l);
            default: return 32'(busy_l);
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic expect_v(int kind, logic [31:0] v, string tag);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.v    = v;
        sbq.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.tag, obs(e.kind), e.v);
        end
        chk("inv_popcount", 32'($countones(gnt)), 32'($countones(out_busy)));
        if (out_busy == 2'b11) chk("inv_owner_unique", 32'(out_owner[1:0] != out_owner[3:2]), 32'd1);
    endtask

    task automatic set_code(int ch, logic [2:0] v);
        code[ch*CODEW +: CODEW] = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ch;
        // reset with everything requesting output 0
        req = 4'b1111;
        code = '0;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            expect_v(0, 0, "rst_gnt");
            expect_v(1, 0, "rst_busy");
            expect_v(2, 0, "rst_owner");
            expect_v(3, 0, "rst_ledsel");
            cyc();
        end
        rst = 1'b0;
        expect_v(0, 32'b0001, "first_gnt");
        expect_v(1, 32'b01, "first_busy");
        expect_v(2, 0, "first_owner");
        cyc();
        repeat (3) begin
            expect_v(0, 32'b0001, "rr_ch0_tenure");
            cyc();
        end
        for (int n = 1; n <= 4; n++) begin
            ch = n % 4;
            expect_v(0, 0, "rr_dead");
            expect_v(1, 0, "rr_dead_busy");
            cyc();
            expect_v(0, 32'(1 << ch), "rr_grant");
            expect_v(2, 32'(ch), "rr_owner");
            cyc();
            if (n < 4) begin
                repeat (3) begin
                    expect_v(0, 32'(1 << ch), "rr_tenure");
                    cyc();
                end
            end
        end

        // uncontended ch2
        req = 4'b0100;
        expect_v(0, 0, "unc_release");
        cyc();
        expect_v(0, 32'b0100, "unc_grant");
        expect_v(2, 32'd2, "unc_owner");
        expect_v(3, 0, "unc_ledsel");
        cyc();
        repeat (99) begin
            expect_v(0, 32'b0100, "unc_hold");
            cyc();
        end

        // ch1 takes output 1, then moves to output 0, then drops
        req = 4'b0010;
        set_code(1, 3'b001);
        expect_v(0, 32'b0010, "rel_gnt_out1");
        expect_v(1, 32'b10, "rel_busy_out1");
        expect_v(2, 32'b0100, "rel_owner_out1");
        expect_v(3, 32'b0010, "rel_ledsel_out1");
        cyc();
        expect_v(0, 32'b0010, "rel_hold_out1");
        cyc();
        set_code(1, 3'b000);
        expect_v(0, 0, "rel_code_drop");
        expect_v(1, 0, "rel_code_busy");
        cyc();
        expect_v(0, 32'b0010, "rel_gnt_out0");
        expect_v(1, 32'b01, "rel_busy_out0");
        expect_v(2, 32'b0001, "rel_owner_out0");
        expect_v(3, 0, "rel_ledsel_out0");
        cyc();
        req = 4'b0000;
        expect_v(0, 0, "rel_req_drop");
        cyc();

        // legacy map
        rst = 1'b1;
        expect_v(0, 0, "rst2_gnt");
        expect_v(4, 0, "rst2_leg_gnt");
        cyc();
        rst = 1'b0;
        req = 4'b0011;
        set_code(0, 3'b101);
        set_code(1, 3'b111);
        expect_v(4, 32'b0011, "leg_gnt");
        expect_v(5, 32'b0010, "leg_ledsel");
        expect_v(6, 32'b11, "leg_busy");
        expect_v(0, 32'b0001, "m1_same_dest_gnt");
        expect_v(1, 32'b10, "m1_same_dest_busy");
        cyc();

        // both outputs busy, then reset mid-tenure
        set_code(0, 3'b000);
        set_code(1, 3'b001);
        expect_v(0, 0, "mid_dest_change");
        cyc();
        expect_v(0, 32'b0011, "mid_gnt");
        expect_v(1, 32'b11, "mid_busy");
        expect_v(2, 32'b0100, "mid_owner");
        expect_v(3, 32'b0010, "mid_ledsel");
        cyc();
        rst = 1'b1;
        req = 4'b1110;
        for (int i = 0; i < NCH; i++) set_code(i, 3'b001);
        expect_v(0, 0, "mid_rst_gnt");
        expect_v(1, 0, "mid_rst_busy");
        expect_v(2, 0, "mid_rst_owner");
        expect_v(3, 0, "mid_rst_ledsel");
        cyc();
        rst = 1'b0;
        expect_v(0, 32'b0010, "post_rst_gnt");
        expect_v(1, 32'b10, "post_rst_busy");
        expect_v(2, 32'b0100, "post_rst_owner");
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
